// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch (IF) and load/store (MEM).
// MEM has priority; IF wins after STARVE_MAX consecutive lost arbitrations.
//
// state | meaning
// IDLE  | no access in flight, arbitrating on current requests
// BUSY  | RAM cycle in progress, ram_ce held for LATENCY cycles
// DONE  | owner ack cycle, arbitrating again so accesses can chain
module mem_arbiter #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LAT_LAST  = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [3:0]  starve;
    logic        owner_mem;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic [3:0]  lat_sel;

    logic arb_en;
    logic both_req;
    logic grant_if;
    logic grant_mem;
    logic last_beat;

    always_comb begin
        arb_en    = (state == IDLE) || (state == DONE);
        both_req  = if_req & mem_req;
        grant_if  = arb_en & if_req & (~mem_req | (starve == STARVE_LIM));
        grant_mem = arb_en & mem_req & ~grant_if;
        last_beat = (state == BUSY) && (cnt == LAT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            starve    <= 4'd0;
            owner_mem <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_we    <= 1'b0;
            lat_sel   <= 4'd0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (grant_if) begin
                        state     <= BUSY;
                        cnt       <= 4'd0;
                        owner_mem <= 1'b0;
                        lat_addr  <= if_addr;
                        lat_we    <= 1'b0;
                        lat_sel   <= 4'b1111;
                        lat_wdata <= 32'd0;
                    end else if (grant_mem) begin
                        state     <= BUSY;
                        cnt       <= 4'd0;
                        owner_mem <= 1'b1;
                        lat_addr  <= mem_addr;
                        lat_we    <= mem_we;
                        lat_sel   <= mem_sel;
                        lat_wdata <= mem_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 4'd1;
                    if (last_beat) begin
                        state <= DONE;
                        if (owner_mem) begin
                            mem_ack <= 1'b1;
                            if (!lat_we)
                                mem_rdata <= ram_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // starve never exceeds STARVE_LIM because IF wins once it is reached
            if (grant_if)
                starve <= 4'd0;
            else if (grant_mem && both_req)
                starve <= starve + 4'd1;
        end
    end

    always_comb begin
        ram_ce    = (state == BUSY);
        ram_we    = ram_ce & lat_we;
        ram_sel   = ram_ce ? lat_sel : 4'd0;
        ram_addr  = lat_addr;
        ram_wdata = lat_wdata;
        stall_if  = if_req & ~if_ack;
        stall_mem = mem_req & ~mem_ack;
    end

endmodule
